// File: rtl/blowfish_pkg.sv
// Shared types and constants for the Blowfish CBC feeder and its chaining datapath.
package blowfish_pkg;
    localparam int HALF_W  = 32;
    localparam int BLOCK_W = 2 * HALF_W;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

    typedef logic [BLOCK_W-1:0] bf_block_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_LAUNCH,
        ST_WAIT,
        ST_OUTPUT
    } cbc_state_e;
endpackage

// File: rtl/blowfish_cbc_ctrl_if.sv
// Plaintext/ciphertext streams, IV/mode controls and the core request/response bundle.
interface blowfish_cbc_ctrl_if;
    import blowfish_pkg::*;

    logic      iv_load;
    bf_block_t iv;
    logic      chain_en;
    logic      in_valid, in_ready, in_last;
    bf_block_t in_data;
    logic      out_valid, out_ready, out_last;
    bf_block_t out_data;
    logic      core_clr, core_start, core_enc, core_done;
    bf_block_t core_plaintext, core_ct;
    logic      busy, err;

    modport slave (
        input  iv_load, iv, chain_en, in_valid, in_data, in_last, out_ready, core_ct, core_done,
        output in_ready, out_valid, out_data, out_last, core_clr, core_start, core_enc,
               core_plaintext, busy, err
    );

    modport master (
        output iv_load, iv, chain_en, in_valid, in_data, in_last, out_ready, core_ct, core_done,
        input  in_ready, out_valid, out_data, out_last, core_clr, core_start, core_enc,
               core_plaintext, busy, err
    );
endinterface

// File: rtl/blowfish_cbc_chain.sv
// CBC chain register and stored IV, plus the XOR that forms the block sent to the core.
module blowfish_cbc_chain
    import blowfish_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      iv_load,
    input  bf_block_t iv,
    input  logic      chain_en,
    input  bf_block_t in_data,
    input  logic      ct_load,
    input  bf_block_t ct,
    input  logic      restore,
    output bf_block_t blk
);
    bf_block_t chain_q, chain_d, iv_q, iv_d, link;

    always_comb begin
        iv_d    = iv_load ? iv : iv_q;
        chain_d = chain_q;
        if (iv_load)      chain_d = iv;
        else if (ct_load) chain_d = ct;
        else if (restore) chain_d = iv_q;
    end

    // A fresh IV presented with the accepting block must chain that same block.
    assign link = iv_load ? iv : chain_q;
    assign blk  = in_data ^ (chain_en ? link : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= '0;
            iv_q    <= '0;
        end else begin
            chain_q <= chain_d;
            iv_q    <= iv_d;
        end
    end
endmodule

// File: rtl/blowfish_cbc_ctrl.sv
// Blowfish CBC feeder: chains plaintext and runs the core one block at a time.
// Define BLOWFISH_CBC_TIMEOUT_EN to add a core watchdog and the sticky err flag.
module blowfish_cbc_ctrl
    import blowfish_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input logic                clk,
    input logic                rst,
    blowfish_cbc_ctrl_if.slave bus
);
    cbc_state_e state_q, state_d;
    logic       in_ready_q, in_ready_d, busy_q, busy_d;
    logic       out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic       core_clr_q, core_clr_d, core_start_q, core_start_d;
    logic       last_q, last_d, done_q;
    bf_block_t  out_data_q, out_data_d, core_pt_q, core_pt_d, chain_xor;
    logic       accept, done_rise, out_fire, timeout;

    assign accept    = (state_q == ST_IDLE) && in_ready_q && bus.in_valid;
    // A done flag still high from a failed clear never counts as completion.
    assign done_rise = bus.core_done && !done_q;
    assign out_fire  = (state_q == ST_OUTPUT) && bus.out_ready;

    blowfish_cbc_chain u_chain (
        .clk      (clk),
        .rst      (rst),
        .iv_load  ((state_q == ST_IDLE) && bus.iv_load),
        .iv       (bus.iv),
        .chain_en (bus.chain_en),
        .in_data  (bus.in_data),
        .ct_load  ((state_q == ST_WAIT) && done_rise),
        .ct       (bus.core_ct),
        .restore  (out_fire && last_q),
        .blk      (chain_xor)
    );

`ifdef BLOWFISH_CBC_TIMEOUT_EN
    logic [7:0] wd_cnt_q, wd_cnt_d;
    logic       err_q, err_d;

    always_comb begin
        wd_cnt_d = (state_q == ST_WAIT) ? wd_cnt_q + 8'd1 : 8'd0;
        err_d    = err_q | timeout;
    end

    assign timeout = (state_q == ST_WAIT) && !done_rise && (wd_cnt_d == TIMEOUT_CYCLES[7:0]);
    assign bus.err = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt_q <= 8'd0;
            err_q    <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            err_q    <= err_d;
        end
    end
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
    assign bus.err = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        core_clr_d   = 1'b0;
        core_start_d = core_start_q;
        core_pt_d    = core_pt_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        last_d       = last_q;
        case (state_q)
            ST_IDLE: if (accept) begin
                core_pt_d  = chain_xor;
                last_d     = bus.in_last;
                core_clr_d = 1'b1;
                state_d    = ST_CLR;
            end
            ST_CLR: begin
                core_start_d = 1'b1;
                state_d      = ST_LAUNCH;
            end
            ST_LAUNCH: state_d = ST_WAIT;
            ST_WAIT: if (done_rise) begin
                core_start_d = 1'b0;
                out_valid_d  = 1'b1;
                out_data_d   = bus.core_ct;
                out_last_d   = last_q;
                state_d      = ST_OUTPUT;
            end else if (timeout) begin
                core_start_d = 1'b0;
                core_clr_d   = 1'b1;
                state_d      = ST_IDLE;
            end
            ST_OUTPUT: if (bus.out_ready) begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            core_clr_q   <= 1'b0;
            core_start_q <= 1'b0;
            core_pt_q    <= '0;
            last_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            core_clr_q   <= core_clr_d;
            core_start_q <= core_start_d;
            core_pt_q    <= core_pt_d;
            last_q       <= last_d;
            done_q       <= bus.core_done;
        end
    end

    assign bus.in_ready       = in_ready_q;
    assign bus.busy           = busy_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_data       = out_data_q;
    assign bus.out_last       = out_last_q;
    assign bus.core_clr       = core_clr_q;
    assign bus.core_start     = core_start_q;
    assign bus.core_enc       = core_start_q;
    assign bus.core_plaintext = core_pt_q;
endmodule

// File: tb/tb_blowfish_cbc_ctrl.sv
// Bench for blowfish_cbc_ctrl: XOR-key core model, vector table, random blocks vs a CBC model.
module tb_blowfish_cbc_ctrl;
    localparam logic [63:0] K = 64'h0123456789ABCDEF;
    localparam int CORE_LAT = 30;
    localparam int EXP_LAT  = 34;

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic        cen;
        logic        ivl;
        logic [63:0] iv;
        int          stall;
        logic [63:0] exp;
        logic        exp_last;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    blowfish_cbc_ctrl_if bus();
    blowfish_cbc_ctrl #(.TIMEOUT_CYCLES(40)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Core model: ct = pt ^ K, sticky done CORE_LAT cycles after start is seen.
    logic        core_run = 1'b0, core_done_r = 1'b0, core_stuck = 1'b0, core_hang = 1'b0;
    int          core_cnt = 0;
    logic [63:0] core_ct_r = '0;
    always @(posedge clk) begin
        if (bus.core_clr) begin
            core_run <= 1'b0; core_done_r <= 1'b0; core_cnt <= 0;
        end else if (core_run) begin
            core_cnt <= core_cnt + 1;
            if (core_cnt + 1 == CORE_LAT) begin core_done_r <= 1'b1; core_run <= 1'b0; end
        end else if (bus.core_start && !core_done_r && !core_hang) begin
            core_run <= 1'b1; core_cnt <= 0; core_ct_r <= bus.core_plaintext ^ K;
        end
    end
    assign bus.core_done = core_done_r | core_stuck;
    assign bus.core_ct   = core_ct_r;

    int n_vec = 0, n_miss = 0;
    logic [63:0] m_chain = '0, m_iv = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_step(input vec_t v);
        logic [63:0] ct;
        if (v.ivl) begin m_iv = v.iv; m_chain = v.iv; end
        ct = (v.data ^ (v.cen ? m_chain : 64'h0)) ^ K;
        m_chain = v.last ? m_iv : ct;
        return ct;
    endfunction

    task automatic send(input vec_t v);
        int t = 0;
        while (!bus.in_ready && t < 60) begin @(negedge clk); t++; end
        check("in_ready_wait", {63'h0, bus.in_ready}, 64'h1);
        bus.in_valid = 1'b1; bus.in_data = v.data; bus.in_last = v.last;
        bus.chain_en = v.cen; bus.iv_load = v.ivl; bus.iv = v.iv;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.iv_load = 1'b0;
    endtask

    task automatic run_block(input vec_t v, input string tag);
        int lat;
        send(v);
        check({tag, "_clr"}, {63'h0, bus.core_clr}, 64'h1);
        @(negedge clk);
        check({tag, "_start"}, {62'h0, bus.core_start, bus.core_clr}, 64'h2);
        check({tag, "_pt"}, bus.core_plaintext, v.exp ^ K);
        lat = 2;
        while (!bus.out_valid && lat < 200) begin @(negedge clk); lat++; end
        check({tag, "_lat"}, 64'(lat), 64'(EXP_LAT));
        check({tag, "_data"}, bus.out_data, v.exp);
        check({tag, "_last"}, {63'h0, bus.out_last}, {63'h0, v.exp_last});
        for (int i = 0; i < v.stall; i++) begin
            @(negedge clk);
            check({tag, "_stall_data"}, bus.out_data, v.exp);
            check({tag, "_stall_rdy"}, {62'h0, bus.in_ready, bus.out_valid}, 64'h1);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_post"}, {62'h0, bus.out_valid, bus.in_ready}, 64'h1);
    endtask

    vec_t tbl[6];
    vec_t v;
    logic seen;

    initial begin
        tbl[0] = '{64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 0, 64'h0123456789ABCDEF, 1'b1};
        tbl[1] = '{64'h1, 1'b0, 1'b1, 1'b1, 64'hFFFFFFFF00000000, 0, 64'hFEDCBA9889ABCDEE, 1'b0};
        tbl[2] = '{64'h2, 1'b1, 1'b1, 1'b0, 64'h0, 0, 64'hFFFFFFFF00000003, 1'b1};
        tbl[3] = '{64'h0, 1'b1, 1'b1, 1'b1, 64'hA5A5A5A5A5A5A5A5, 0, 64'hA486E0C22C0E684A, 1'b1};
        tbl[4] = '{64'h1122334455667788, 1'b1, 1'b0, 1'b0, 64'h0, 10, 64'h10017623DCCDBA67, 1'b1};
        tbl[5] = '{64'h0, 1'b1, 1'b1, 1'b0, 64'h0, 0, 64'hA486E0C22C0E684A, 1'b1};

        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.chain_en = 1'b0;
        bus.iv_load = 1'b0; bus.iv = '0; bus.out_ready = 1'b0;

        // Reset state
        @(negedge clk); @(negedge clk);
        check("rst_in_ready", {63'h0, bus.in_ready}, 64'h0);
        check("rst_ctrl", {57'h0, bus.out_valid, bus.out_last, bus.core_clr, bus.core_start,
                           bus.core_enc, bus.busy, bus.err}, 64'h0);
        check("rst_out_data", bus.out_data, 64'h0);
        check("rst_core_pt", bus.core_plaintext, 64'h0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {63'h0, bus.in_ready}, 64'h1);

        foreach (tbl[i]) begin
            void'(model_step(tbl[i]));
            run_block(tbl[i], $sformatf("tbl%0d", i));
        end

        // Reset in WAIT drops the block and zeroes the chain
        v = '{64'h7, 1'b0, 1'b1, 1'b1, 64'hDEADBEEFCAFEF00D, 0, 64'h0, 1'b0};
        send(v);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_ctrl", {61'h0, bus.out_valid, bus.core_start, bus.busy}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        m_chain = '0; m_iv = '0;
        v = '{64'h5, 1'b1, 1'b1, 1'b0, 64'h0, 0, 64'h0, 1'b1};
        v.exp = model_step(v);
        run_block(v, "after_rst");

        // Done stuck high through the clear: no completion may be taken
        core_stuck = 1'b1;
        v = '{64'h9, 1'b1, 1'b0, 1'b0, 64'h0, 0, 64'h0, 1'b1};
        send(v);
        seen = 1'b0;
        repeat (34) begin @(negedge clk); seen |= bus.out_valid; end
        check("stuck_done_no_out", {63'h0, seen}, 64'h0);
        rst = 1'b1; @(negedge clk); rst = 1'b0; core_stuck = 1'b0;
        m_chain = '0; m_iv = '0;

        // Random blocks against the CBC model
        for (int n = 0; n < 24; n++) begin
            v.data = {$urandom, $urandom};
            v.cen  = 1'($urandom_range(0, 1));
            v.last = ($urandom_range(0, 3) == 0);
            v.ivl  = ($urandom_range(0, 5) == 0);
            v.iv   = {$urandom, $urandom};
            v.stall = $urandom_range(0, 3);
            v.exp  = model_step(v);
            v.exp_last = v.last;
            run_block(v, $sformatf("rnd%0d", n));
        end

`ifdef BLOWFISH_CBC_TIMEOUT_EN
        // Watchdog: err rises after the 40th WAIT cycle, block dropped
        core_hang = 1'b1;
        v = '{64'h3, 1'b1, 1'b0, 1'b0, 64'h0, 0, 64'h0, 1'b1};
        send(v);
        seen = 1'b0;
        for (int lat = 2; lat <= 42; lat++) begin @(negedge clk); seen |= bus.out_valid; end
        check("to_err_early", {63'h0, bus.err}, 64'h0);
        @(negedge clk);
        seen |= bus.out_valid;
        check("to_fire", {60'h0, bus.err, bus.core_clr, bus.busy, bus.core_start}, 64'hC);
        check("to_idle_rdy", {63'h0, bus.in_ready}, 64'h1);
        repeat (5) begin @(negedge clk); seen |= bus.out_valid; end
        check("to_no_out", {63'h0, seen}, 64'h0);
        check("to_err_sticky", {62'h0, bus.err, bus.core_clr}, 64'h2);
        core_hang = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end
endmodule
